// File: rtl/ball_move.sv
// ball_move: moves the ball sprite once per video frame.
//
// Position is kept in signed fixed point (pixels * FIXED_POINT_MULTIPLIER).
// Speed is in 1/FIXED_POINT_MULTIPLIER px per frame. Collisions reported
// pixel by pixel during a frame are accumulated into side flags. After each
// accepted startOfFrame the ball reflects, gets a flipper kick and gravity,
// and then moves.
//
// Ports
//   clk                    system clock
//   resetN                 asynchronous active-low reset
//   startOfFrame           one-cycle pulse per video frame
//   collisionSmileyBorders ball pixel overlaps a border on this cycle
//   collisionSmileyFlipper ball pixel overlaps the flipper on this cycle
//   pause                  level; holds the game while high
//   offsetX, offsetY       pixel coordinate inside the 32x32 ball sprite
//   launch                 one-cycle key pulse (start / restart)
//   topLeftX, topLeftY     ball sprite position in px
//   speedX, speedY         speed in 1/64 px per frame
//   state                  0 IDLE, 1 RUN, 2 PAUSED
module ball_move #(
  parameter int INITIAL_X              = 280,
  parameter int INITIAL_Y              = 185,
  parameter int INITIAL_SPEED_X        = 128,
  parameter int GRAVITY                = 2,
  parameter int FLIPPER_KICK           = 320,
  parameter int MAX_SPEED              = 512,
  parameter int FIXED_POINT_MULTIPLIER = 64
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collisionSmileyBorders,
  input  logic               collisionSmileyFlipper,
  input  logic               pause,
  input  logic [4:0]         offsetX,
  input  logic [4:0]         offsetY,
  input  logic               launch,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic signed [10:0] speedX,
  output logic signed [10:0] speedY,
  output logic [1:0]         state
);

  localparam int FRAC_W = $clog2(FIXED_POINT_MULTIPLIER);
  localparam int POS_W  = 18;
  localparam int SPD_W  = 11;
  localparam int ACC_W  = 13;

  localparam logic signed [POS_W-1:0] INIT_X_FX = POS_W'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam logic signed [POS_W-1:0] INIT_Y_FX = POS_W'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
  localparam logic signed [POS_W:0]   X_MAX_FX  = (POS_W+1)'(608 * FIXED_POINT_MULTIPLIER);
  localparam logic signed [POS_W:0]   Y_MAX_FX  = (POS_W+1)'(448 * FIXED_POINT_MULTIPLIER);
  localparam logic signed [SPD_W-1:0] INIT_SPD  = SPD_W'(INITIAL_SPEED_X);
  localparam logic signed [ACC_W-1:0] KICK_A    = ACC_W'(FLIPPER_KICK);
  localparam logic signed [ACC_W-1:0] GRAV_A    = ACC_W'(GRAVITY);
  localparam logic signed [ACC_W-1:0] MAX_A     = ACC_W'(MAX_SPEED);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic signed [POS_W-1:0] pos_x, pos_y;
  logic signed [SPD_W-1:0] spd_x, spd_y;
  logic hit_left, hit_right, hit_top, hit_bottom, hit_flipper;
  // vld_p1: cycle S+1, speed updated, position move pending.
  // vld_p2: cycle S+2, position just moved.
  logic vld_p1, vld_p2;

  function automatic logic signed [SPD_W-1:0] sat_speed(input logic signed [ACC_W-1:0] v);
    if (v > MAX_A)       return SPD_W'(MAX_A);
    else if (v < -MAX_A) return SPD_W'(-MAX_A);
    else                 return SPD_W'(v);
  endfunction

  function automatic logic signed [POS_W-1:0] clamp_pos(input logic signed [POS_W:0] v,
                                                        input logic signed [POS_W:0] hi);
    if (v < 0)       return '0;
    else if (v > hi) return POS_W'(hi);
    else             return POS_W'(v);
  endfunction

  // Side decode for the pixel presented this cycle; a corner pixel may hit two sides.
  logic cur_left, cur_right, cur_top, cur_bottom, cur_flipper;
  assign cur_left    = collisionSmileyBorders && (offsetX < 5'd8);
  assign cur_right   = collisionSmileyBorders && (offsetX >= 5'd24);
  assign cur_top     = collisionSmileyBorders && (offsetY < 5'd8);
  assign cur_bottom  = collisionSmileyBorders && (offsetY >= 5'd24);
  assign cur_flipper = collisionSmileyFlipper;

  // A collision on the startOfFrame cycle still belongs to the ending frame.
  logic eff_left, eff_right, eff_top, eff_bottom, eff_flipper;
  assign eff_left    = hit_left    | cur_left;
  assign eff_right   = hit_right   | cur_right;
  assign eff_top     = hit_top     | cur_top;
  assign eff_bottom  = hit_bottom  | cur_bottom;
  assign eff_flipper = hit_flipper | cur_flipper;

  logic busy, sof_take;
  assign busy     = vld_p1 | vld_p2;
  assign sof_take = (state_q == RUN) && !pause && startOfFrame && !busy;

  // Speed update: reflect, flipper kick, gravity, then saturate.
  logic signed [ACC_W-1:0] sx_ext, sy_ext, sx_ref, sy_ref, sy_kick, sy_grav;
  assign sx_ext  = ACC_W'(spd_x);
  assign sy_ext  = ACC_W'(spd_y);
  assign sx_ref  = ((eff_left && sx_ext < 0) || (eff_right && sx_ext > 0)) ? -sx_ext : sx_ext;
  assign sy_ref  = ((eff_top && sy_ext < 0) || (eff_bottom && sy_ext > 0)) ? -sy_ext : sy_ext;
  assign sy_kick = (eff_flipper && sy_ref >= 0) ? -KICK_A : sy_ref;
  assign sy_grav = sy_kick + GRAV_A;

  logic signed [POS_W:0] px_sum, py_sum;
  assign px_sum = (POS_W+1)'(pos_x) + (POS_W+1)'(spd_x);
  assign py_sum = (POS_W+1)'(pos_y) + (POS_W+1)'(spd_y);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (pause) state_nxt = PAUSED;
      PAUSED:  if (launch && !pause) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x       <= INIT_X_FX;
      pos_y       <= INIT_Y_FX;
      spd_x       <= '0;
      spd_y       <= '0;
      hit_left    <= 1'b0;
      hit_right   <= 1'b0;
      hit_top     <= 1'b0;
      hit_bottom  <= 1'b0;
      hit_flipper <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
    end else if (state_q == RUN) begin
      if (pause) begin
        // Pause wins: any update in flight is dropped and everything freezes.
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        // Stage p0 -> p1: accepted frame start updates speed.
        vld_p1 <= sof_take;
        // Stage p1 -> p2: position moves with the speed computed one cycle earlier.
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          pos_x <= clamp_pos(px_sum, X_MAX_FX);
          pos_y <= clamp_pos(py_sum, Y_MAX_FX);
        end
        if (sof_take) begin
          spd_x       <= sat_speed(sx_ref);
          spd_y       <= sat_speed(sy_grav);
          hit_left    <= 1'b0;
          hit_right   <= 1'b0;
          hit_top     <= 1'b0;
          hit_bottom  <= 1'b0;
          hit_flipper <= 1'b0;
        end else begin
          // Includes frame starts ignored while busy: their collisions carry over.
          hit_left    <= eff_left;
          hit_right   <= eff_right;
          hit_top     <= eff_top;
          hit_bottom  <= eff_bottom;
          hit_flipper <= eff_flipper;
        end
      end
    end else if (state_q == PAUSED && !(launch && !pause)) begin
      // Frozen while paused.
    end else begin
      // IDLE, leaving PAUSED, or an illegal encoding: ball parked at start.
      pos_x       <= INIT_X_FX;
      pos_y       <= INIT_Y_FX;
      spd_x       <= (state_q == IDLE && launch) ? INIT_SPD : '0;
      spd_y       <= '0;
      hit_left    <= 1'b0;
      hit_right   <= 1'b0;
      hit_top     <= 1'b0;
      hit_bottom  <= 1'b0;
      hit_flipper <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
    end
  end

  assign topLeftX = SPD_W'(pos_x >>> FRAC_W);
  assign topLeftY = SPD_W'(pos_y >>> FRAC_W);
  assign speedX   = spd_x;
  assign speedY   = spd_y;
  assign state    = state_q;

endmodule

// File: doc/ball_move.md
BALL_MOVE -- requirements
Module: ball_move

Interface
REQ-001 SHALL have parameters: INITIAL_X 280, start column px; INITIAL_Y 185, start row px; INITIAL_SPEED_X 128, launch X speed; GRAVITY 2, per-frame Y speed increment; FLIPPER_KICK 320, upward speed magnitude after flipper hit; MAX_SPEED 512, speed saturation magnitude; FIXED_POINT_MULTIPLIER 64, sub-pixel scale (power of 2).
REQ-002 SHALL have ports: clk in 1 system clock; resetN in 1 reset.
REQ-003 SHALL have ports: startOfFrame in 1, one-cycle pulse per video frame; collisionSmileyBorders in 1, per-pixel ball/border overlap; collisionSmileyFlipper in 1, per-pixel ball/flipper overlap; pause in 1, level, game-over hold.
REQ-004 SHALL have ports: offsetX in 5, offsetY in 5, coordinate of the current pixel inside the 32x32 ball sprite, valid when a collision input is high; launch in 1, one-cycle key pulse.
REQ-005 SHALL have ports: topLeftX out 11 signed, topLeftY out 11 signed, ball sprite position in px; speedX out 11 signed, speedY out 11 signed, in 1/64 px per frame; state out 2, 0 IDLE, 1 RUN, 2 PAUSED.
REQ-006 Reset is resetN, asynchronous, active-low; clock is clk; all state on posedge clk.

Function
REQ-007 SHALL keep positions internally as 18-bit signed fixed point (px*FIXED_POINT_MULTIPLIER); topLeftX/Y = internal value arithmetically shifted right by log2(FIXED_POINT_MULTIPLIER).
REQ-008 SHALL implement FSM IDLE, RUN, PAUSED; encoding 3 is illegal and SHALL recover to IDLE on the next clock.
REQ-009 IDLE: position held at INITIAL_X/INITIAL_Y, speeds 0; launch -> RUN with speedX=INITIAL_SPEED_X, speedY=0.
REQ-010 RUN: pause high -> PAUSED on the next clock; pause has priority over any frame update in the same cycle.
REQ-011 PAUSED: position and speed frozen, startOfFrame ignored; launch with pause low -> IDLE, position/speed reinitialised; launch with pause high is ignored.
REQ-012 In RUN, per-frame collision flags hitLeft/hitRight/hitTop/hitBottom/hitFlipper SHALL be set by collision inputs during the frame.
REQ-013 Border side decode: offsetX<8 sets hitLeft; offsetX>=24 sets hitRight; offsetY<8 sets hitTop; offsetY>=24 sets hitBottom; one pixel may set two flags (corner).
REQ-014 collisionSmileyFlipper SHALL set hitFlipper regardless of offset.
REQ-015 A collision on the startOfFrame cycle SHALL belong to the ending frame; all flags clear after that cycle.
REQ-016 Cycle S+1 after startOfFrame S: speed update in order: reflect (hitLeft and speedX<0, hitRight and speedX>0 -> negate speedX; hitTop and speedY<0, hitBottom and speedY>0 -> negate speedY); then hitFlipper and speedY>=0 -> speedY=-FLIPPER_KICK; then speedY+=GRAVITY; then saturate both speeds to [-MAX_SPEED, +MAX_SPEED].
REQ-017 Cycle S+2: position += updated speed; new topLeftX/Y visible at outputs from S+2, i.e. latency 2 clocks from startOfFrame.
REQ-018 Intermediate arithmetic SHALL use at least 13 bits, so no wrap occurs before saturation.
REQ-019 Position SHALL clamp to X in [0, 608] px and Y in [0, 448] px, speed unchanged; reflection is left to the collision path.
REQ-020 startOfFrame arriving while an update is in progress (S+1 or S+2) SHALL be ignored, its collisions carried into the next frame.
REQ-021 In IDLE and PAUSED, collision inputs SHALL NOT set flags; flags SHALL be cleared on entry to RUN.

Reset
REQ-022 resetN low SHALL immediately force state=IDLE, topLeftX=INITIAL_X, topLeftY=INITIAL_Y, speedX=0, speedY=0, all hit flags 0, including mid-update.
REQ-023 After reset release, no movement SHALL occur until launch.

Verification
REQ-024 Reset, then launch, then startOfFrame with no collisions -> at S+2 speedX=128, speedY=2, topLeftX=282, topLeftY=185, state=1.
REQ-025 RUN with speedX=-128; collisionSmileyBorders with offsetX=3, offsetY=16 mid-frame; then startOfFrame -> at S+1 speedX=+128.
REQ-026 RUN with speedY=100; collisionSmileyFlipper pulse; then startOfFrame -> speedY=-318; same with speedY=-50 -> speedY=-48 (no kick).
REQ-027 RUN with speedY=511, no collisions, startOfFrame -> speedY=512; next frame stays 512.
REQ-028 RUN, pause high, three startOfFrame pulses -> state=2, position and speed unchanged; pause low plus launch -> state=0, topLeftX=280, topLeftY=185.
REQ-029 resetN asserted at S+1 -> outputs at reset values within the same cycle; no position update follows release.
